// File: rtl/wb_pkg.sv
// Shared Wishbone interconnect types and constants.
// The address-window mask helper is shared by the decoder and any future crossbar.
package wb_pkg;

  localparam int unsigned WB_AW = 32;
  localparam int unsigned WB_DW = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    MISS = 2'd2,
    TOUT = 2'd3
  } wb_state_e;

  localparam logic [1:0] ERR_MISS = 2'b01;
  localparam logic [1:0] ERR_TOUT = 2'b10;

  // Mask that keeps the bits above a 2^w-byte window.
  function automatic logic [WB_AW-1:0] win_mask(input logic [7:0] w);
    return ~((32'd1 << w) - 32'd1);
  endfunction

endpackage

// File: rtl/wb_addr_decode.sv
// Combinational base/window address decoder with lowest-index priority.
// Produces a one-hot hit vector and an any-hit flag.
module wb_addr_decode
  import wb_pkg::*;
#(
  parameter int unsigned             N           = 3,
  parameter logic [N*WB_AW-1:0]      BASE_ADDRS  = {32'h3000_8000, 32'h3000_4000, 32'h3000_0000},
  parameter logic [N*8-1:0]          ADDR_WIDTHS = {8'd12, 8'd10, 8'd11}
) (
  input  logic [WB_AW-1:0] adr_i,
  output logic [N-1:0]     hit_o,
  output logic             any_hit_o
);

  // Walk from the top slot down so the lowest matching index overwrites the rest.
  always_comb begin
    hit_o     = '0;
    any_hit_o = 1'b0;
    for (int k = int'(N) - 1; k >= 0; k--) begin
      if ((adr_i & win_mask(ADDR_WIDTHS[8*k +: 8])) == BASE_ADDRS[WB_AW*k +: WB_AW]) begin
        hit_o     = '0;
        hit_o[k]  = 1'b1;
        any_hit_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wishbone_mux_n.sv
// 1-master/N-slave Wishbone classic interconnect with registered decode,
// decode-miss and timeout responses, master-abort handling and sticky error status.
module wishbone_mux_n
  import wb_pkg::*;
#(
  parameter int unsigned                N_SLAVES    = 3,
  parameter logic [N_SLAVES*WB_AW-1:0]  BASE_ADDRS  = {32'h3000_8000, 32'h3000_4000, 32'h3000_0000},
  parameter logic [N_SLAVES*8-1:0]      ADDR_WIDTHS = {8'd12, 8'd10, 8'd11},
  parameter logic [9:0]                 TIMEOUT     = 10'd255,
  parameter logic [WB_DW-1:0]           ERR_DATA    = 32'hDEAD_BEEF
) (
  input  logic                         wb_clk_i,
  input  logic                         wb_rst_i,
  input  logic                         wbs_stb_i,
  input  logic                         wbs_cyc_i,
  input  logic                         wbs_we_i,
  input  logic [3:0]                   wbs_sel_i,
  input  logic [WB_DW-1:0]             wbs_dat_i,
  input  logic [WB_AW-1:0]             wbs_adr_i,
  output logic                         wbs_ack_o,
  output logic [WB_DW-1:0]             wbs_dat_o,
  output logic [N_SLAVES-1:0]          wbm_stb_o,
  output logic [N_SLAVES-1:0]          wbm_cyc_o,
  output logic                         wbm_we_o,
  output logic [3:0]                   wbm_sel_o,
  output logic [WB_DW-1:0]             wbm_dat_o,
  output logic [WB_AW-1:0]             wbm_adr_o,
  input  logic [N_SLAVES-1:0]          wbm_ack_i,
  input  logic [N_SLAVES*WB_DW-1:0]    wbm_dat_i,
  output logic                         err_o,
  output logic [1:0]                   err_code_o,
  output logic [WB_AW-1:0]             err_adr_o,
  input  logic                         err_clr_i
);

  localparam int unsigned TW    = $clog2(int'(TIMEOUT) + 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 10'd1);

  wb_state_e             state_q, state_d;
  logic [N_SLAVES-1:0]   sel_q, sel_d;
  logic [TW-1:0]         tcnt_q, tcnt_d;
  logic [WB_AW-1:0]      adr_q, adr_d;
  logic [WB_DW-1:0]      dat_q, dat_d;
  logic                  we_q, we_d;
  logic [3:0]            bsel_q, bsel_d;
  logic                  err_q, err_d;
  logic [1:0]            err_code_q, err_code_d;
  logic [WB_AW-1:0]      err_adr_q, err_adr_d;

  logic [N_SLAVES-1:0]   hit;
  logic                  any_hit;
  logic [WB_DW-1:0]      rd_mux;
  logic                  slave_ack;
  logic                  err_set;
  logic [1:0]            err_set_code;
  logic [WB_AW-1:0]      err_set_adr;

  wb_addr_decode #(
    .N           (N_SLAVES),
    .BASE_ADDRS  (BASE_ADDRS),
    .ADDR_WIDTHS (ADDR_WIDTHS)
  ) u_decode (
    .adr_i     (wbs_adr_i),
    .hit_o     (hit),
    .any_hit_o (any_hit)
  );

  always_comb begin
    rd_mux = '0;
    for (int k = 0; k < int'(N_SLAVES); k++) begin
      rd_mux = rd_mux | (wbm_dat_i[WB_DW*k +: WB_DW] & {WB_DW{sel_q[k]}});
    end
  end

  assign slave_ack = |(wbm_ack_i & sel_q);

  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    tcnt_d       = tcnt_q;
    adr_d        = adr_q;
    dat_d        = dat_q;
    we_d         = we_q;
    bsel_d       = bsel_q;
    err_set      = 1'b0;
    err_set_code = 2'b00;
    err_set_adr  = '0;
    wbs_ack_o    = 1'b0;
    wbs_dat_o    = '0;
    wbm_stb_o    = '0;
    wbm_cyc_o    = '0;

    case (state_q)
      IDLE: begin
        if (wbs_cyc_i && wbs_stb_i) begin
          adr_d  = wbs_adr_i;
          dat_d  = wbs_dat_i;
          we_d   = wbs_we_i;
          bsel_d = wbs_sel_i;
          sel_d  = hit;
          tcnt_d = '0;
          if (any_hit) begin
            state_d = BUSY;
          end else begin
            state_d      = MISS;
            err_set      = 1'b1;
            err_set_code = ERR_MISS;
            err_set_adr  = wbs_adr_i;
          end
        end
      end
      BUSY: begin
        wbm_stb_o = sel_q;
        wbm_cyc_o = sel_q;
        wbs_dat_o = rd_mux;
        // A master abort takes priority: any ack arriving in that cycle is swallowed.
        if (!wbs_cyc_i) begin
          state_d = IDLE;
        end else if (slave_ack) begin
          wbs_ack_o = 1'b1;
          state_d   = IDLE;
        end else if (tcnt_q == TLAST) begin
          state_d      = TOUT;
          err_set      = 1'b1;
          err_set_code = ERR_TOUT;
          err_set_adr  = adr_q;
        end else if (tcnt_q != {TW{1'b1}}) begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      MISS, TOUT: begin
        wbs_ack_o = wbs_cyc_i;
        wbs_dat_o = ERR_DATA;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Only the first error is kept; a clear in the same cycle as a new error lets it in.
  always_comb begin
    err_d      = err_q;
    err_code_d = err_code_q;
    err_adr_d  = err_adr_q;
    if (err_set && (!err_q || err_clr_i)) begin
      err_d      = 1'b1;
      err_code_d = err_set_code;
      err_adr_d  = err_set_adr;
    end else if (err_clr_i) begin
      err_d      = 1'b0;
      err_code_d = 2'b00;
      err_adr_d  = '0;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q    <= IDLE;
      sel_q      <= '0;
      tcnt_q     <= '0;
      adr_q      <= '0;
      dat_q      <= '0;
      we_q       <= 1'b0;
      bsel_q     <= '0;
      err_q      <= 1'b0;
      err_code_q <= 2'b00;
      err_adr_q  <= '0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      tcnt_q     <= tcnt_d;
      adr_q      <= adr_d;
      dat_q      <= dat_d;
      we_q       <= we_d;
      bsel_q     <= bsel_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
      err_adr_q  <= err_adr_d;
    end
  end

  assign wbm_we_o   = we_q;
  assign wbm_sel_o  = bsel_q;
  assign wbm_dat_o  = dat_q;
  assign wbm_adr_o  = adr_q;
  assign err_o      = err_q;
  assign err_code_o = err_code_q;
  assign err_adr_o  = err_adr_q;

endmodule
